// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store unit
package lsu_pkg;

    // FSM states of the memory-stage controller
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    // RV32I load/store func3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // byte-enable width of the 32-bit data bus
    localparam int BE_W = 4;

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - req/ack data-memory bus between the lsu and data memory
interface lsu_if;
    import lsu_pkg::*;

    logic            mem_req;
    logic            mem_we;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_wdata;
    logic [BE_W-1:0] mem_be;
    logic            mem_ack;
    logic [31:0]     mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - legality check, store lane replication, byte enables, load extension
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]      func3,
    input  logic [1:0]      addr_lo,
    input  logic            is_store,
    input  logic [31:0]     wdata,
    input  logic [31:0]     rdata,
    output logic            legal,
    output logic [31:0]     wdata_rep,
    output logic [BE_W-1:0] be,
    output logic [31:0]     rdata_ext
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = rdata[{addr_lo, 3'b000} +: 8];
    assign lane_h = rdata[{addr_lo[1], 4'b0000} +: 16];

    // size decode: legality, byte enables and store lane replication
    always_comb begin
        legal     = 1'b0;
        be        = '0;
        wdata_rep = wdata;
        case (func3)
            F3_B, F3_BU: begin
                legal     = 1'b1;
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                legal     = !addr_lo[0];
                be        = 4'b0011 << addr_lo;
                wdata_rep = {2{wdata[15:0]}};
            end
            F3_W: begin
                legal     = (addr_lo == 2'b00);
                be        = 4'b1111;
                wdata_rep = wdata;
            end
            default: legal = 1'b0;
        endcase
        // unsigned variants have no store counterpart
        if (is_store && func3[2]) begin
            legal = 1'b0;
        end
    end

    // load lane extraction with sign or zero extension
    always_comb begin
        rdata_ext = '0;
        case (func3)
            F3_B:    rdata_ext = {{24{lane_b[7]}}, lane_b};
            F3_BU:   rdata_ext = {24'h0, lane_b};
            F3_H:    rdata_ext = {{16{lane_h[15]}}, lane_h};
            F3_HU:   rdata_ext = {16'h0, lane_h};
            F3_W:    rdata_ext = rdata;
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I memory-stage load/store unit; LSU_TIMEOUT_EN enables the BUSY timeout abort
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata2,
    output logic [31:0] rdata3,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    lsu_if.master       mem
);

    lsu_state_t      state_q, state_d;
    logic [31:0]     addr_q;
    logic            we_q;
    logic [31:0]     wdata_q;
    logic [BE_W-1:0] be_q;
    logic [2:0]      func3_q;
    logic [1:0]      addr_lo_q;
    logic [31:0]     rdata_q;
    logic            err_q;

    logic            req;
    logic            in_idle;
    logic            accept;
    logic            reject;
    logic            ack_hit;
    logic            tmo_hit;

    logic [2:0]      al_func3;
    logic [1:0]      al_addr_lo;
    logic            al_store;
    logic            al_legal;
    logic [31:0]     al_wdata_rep;
    logic [BE_W-1:0] al_be;
    logic [31:0]     al_rdata_ext;

    assign req     = rd_en | wr_en;
    assign in_idle = (state_q == IDLE);
    assign accept  = in_idle && req && al_legal;
    assign reject  = in_idle && req && !al_legal;
    assign ack_hit = (state_q == BUSY) && mem.mem_ack;

    // decode the live request in IDLE, the captured one while a transfer is in flight
    assign al_func3   = in_idle ? func3      : func3_q;
    assign al_addr_lo = in_idle ? addr[1:0]  : addr_lo_q;
    assign al_store   = in_idle ? wr_en      : we_q;

    lsu_align u_align (
        .func3     (al_func3),
        .addr_lo   (al_addr_lo),
        .is_store  (al_store),
        .wdata     (wdata2),
        .rdata     (mem.mem_rdata),
        .legal     (al_legal),
        .wdata_rep (al_wdata_rep),
        .be        (al_be),
        .rdata_ext (al_rdata_ext)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_q;

    // count BUSY cycles; cleared whenever the FSM is elsewhere
    always_ff @(posedge clk) begin
        if (rst || state_q != BUSY) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
        end
    end

    assign tmo_hit = (state_q == BUSY) && !mem.mem_ack &&
                     (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic; DONE ignores the still-held request
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (mem.mem_ack || tmo_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // outputs: stall is combinational so the request cycle itself is held
    always_comb begin
        stall       = accept || (state_q == BUSY);
        mem.mem_req = (state_q == BUSY);
        misalign    = reject;
        bus_err     = (state_q == DONE) && err_q;
    end

    // bus field capture, load result and abort flag
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            be_q      <= '0;
            func3_q   <= '0;
            addr_lo_q <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= tmo_hit;
            if (accept) begin
                addr_q    <= {addr[31:2], 2'b00};
                we_q      <= wr_en;
                wdata_q   <= wr_en ? al_wdata_rep : '0;
                be_q      <= al_be;
                func3_q   <= func3;
                addr_lo_q <= addr[1:0];
            end
            if (reject && !wr_en) begin
                rdata_q <= '0;
            end
            if (ack_hit && !we_q) begin
                rdata_q <= al_rdata_ext;
            end
            if (tmo_hit) begin
                rdata_q <= '0;
            end
        end
    end

    assign rdata3        = rdata_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_be    = be_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed scoreboard bench for lsu
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] wdata2;
    logic [31:0] rdata3;
    logic        stall;
    logic        misalign;
    logic        bus_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    lsu_if mem_bus ();

    lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .func3    (func3),
        .addr     (addr),
        .wdata2   (wdata2),
        .rdata3   (rdata3),
        .stall    (stall),
        .misalign (misalign),
        .bus_err  (bus_err),
        .mem      (mem_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // legal access acked on BUSY cycle k+1; expected result goes through the scoreboard
    task automatic xfer(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int k, input logic [31:0] rd,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
        int stalls;
        logic [31:0] e;
        exp_q.push_back(exp_rdata);
        rd_en  = !we;
        wr_en  = we;
        func3  = f3;
        addr   = a;
        wdata2 = wd;
        #1;
        stalls = stall ? 1 : 0;
        chk("c0_req", mem_bus.mem_req, 32'd0);
        chk("c0_misalign", misalign, 32'd0);
        for (int i = 0; i <= k; i++) begin
            step();
            if (stall) stalls++;
            chk("busy_req", mem_bus.mem_req, 32'd1);
            chk("busy_addr", mem_bus.mem_addr, exp_addr);
            chk("busy_be", mem_bus.mem_be, exp_be);
            if (i == 0) begin
                chk("busy_we", mem_bus.mem_we, we);
                if (we) chk("busy_wdata", mem_bus.mem_wdata, exp_wdata);
            end
            mem_bus.mem_ack   = (i == k);
            mem_bus.mem_rdata = (i == k) ? rd : 32'hDEADBEEF;
        end
        step();
        mem_bus.mem_ack = 1'b0;
        chk("done_stall", stall, 32'd0);
        chk("done_req", mem_bus.mem_req, 32'd0);
        chk("done_bus_err", bus_err, 32'd0);
        chk("stall_cycles", stalls, k + 2);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("rdata3", rdata3, e);
        end
        step();
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    // illegal access: one misalign pulse, no stall, no bus request
    task automatic illegal(input bit we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] exp_rdata);
        rd_en  = !we;
        wr_en  = we;
        func3  = f3;
        addr   = a;
        wdata2 = 32'h5555AAAA;
        #1;
        chk("ill_misalign", misalign, 32'd1);
        chk("ill_stall", stall, 32'd0);
        chk("ill_req", mem_bus.mem_req, 32'd0);
        step();
        rd_en = 1'b0;
        wr_en = 1'b0;
        #1;
        chk("ill_req_after", mem_bus.mem_req, 32'd0);
        chk("ill_pulse_end", misalign, 32'd0);
        chk("ill_rdata3", rdata3, exp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;
        rst = 1'b1;
        rd_en = 1'b0;
        wr_en = 1'b0;
        func3 = 3'b000;
        addr = '0;
        wdata2 = '0;
        mem_bus.mem_ack = 1'b0;
        mem_bus.mem_rdata = '0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_rdata3", rdata3, 32'd0);
        chk("rst_stall", stall, 32'd0);
        chk("rst_misalign", misalign, 32'd0);
        chk("rst_bus_err", bus_err, 32'd0);
        chk("rst_req", mem_bus.mem_req, 32'd0);
        chk("rst_we", mem_bus.mem_we, 32'd0);
        chk("rst_addr", mem_bus.mem_addr, 32'd0);
        chk("rst_be", mem_bus.mem_be, 32'd0);
        chk("rst_wdata", mem_bus.mem_wdata, 32'd0);
        step();

        xfer(1'b0, 3'b010, 32'h100, 32'h0, 2, 32'h800000FF, 32'h100, 4'b1111, 32'h0, 32'h800000FF);
        xfer(1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80ABCD12, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80);
        xfer(1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80ABCD12, 32'h100, 4'b1000, 32'h0, 32'h00000080);
        xfer(1'b0, 3'b101, 32'h102, 32'h0, 0, 32'h80ABCD12, 32'h100, 4'b1100, 32'h0, 32'h000080AB);
        xfer(1'b0, 3'b001, 32'h100, 32'h0, 1, 32'h80ABCD12, 32'h100, 4'b0011, 32'h0, 32'hFFFFCD12);
        xfer(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 1, 32'h0, 32'h200, 4'b1100, 32'hABCDABCD, 32'hFFFFCD12);
        xfer(1'b1, 3'b000, 32'h201, 32'h0000005A, 0, 32'h0, 32'h200, 4'b0010, 32'h5A5A5A5A, 32'hFFFFCD12);
        xfer(1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 0, 32'h0, 32'h300, 4'b1111, 32'hCAFEF00D, 32'hFFFFCD12);

        illegal(1'b0, 3'b010, 32'h101, 32'h0);
        xfer(1'b0, 3'b000, 32'h101, 32'h0, 0, 32'h0000AA00, 32'h100, 4'b0010, 32'h0, 32'hFFFFFFAA);
        illegal(1'b1, 3'b001, 32'h201, 32'hFFFFFFAA);
        illegal(1'b1, 3'b100, 32'h200, 32'hFFFFFFAA);
        illegal(1'b0, 3'b011, 32'h100, 32'h0);

        // reset in the second BUSY cycle, then a stray ack
        xfer(1'b0, 3'b010, 32'h104, 32'h0, 0, 32'h11223344, 32'h104, 4'b1111, 32'h0, 32'h11223344);
        rd_en = 1'b1;
        func3 = 3'b010;
        addr  = 32'h100;
        step();
        chk("rst_busy1_req", mem_bus.mem_req, 32'd1);
        step();
        rst = 1'b1;
        step();
        rst   = 1'b0;
        rd_en = 1'b0;
        #1;
        chk("rst_mid_req", mem_bus.mem_req, 32'd0);
        chk("rst_mid_stall", stall, 32'd0);
        chk("rst_mid_rdata3", rdata3, 32'd0);
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'h12345678;
        step();
        mem_bus.mem_ack = 1'b0;
        chk("stray_ack_rdata3", rdata3, 32'd0);
        chk("stray_ack_req", mem_bus.mem_req, 32'd0);
        step();
        chk("stray_ack_rdata3_later", rdata3, 32'd0);

        xfer(1'b0, 3'b010, 32'h108, 32'h0, 0, 32'h55AA55AA, 32'h108, 4'b1111, 32'h0, 32'h55AA55AA);

`ifdef LSU_TIMEOUT_EN
        rd_en = 1'b1;
        func3 = 3'b010;
        addr  = 32'h10C;
        busy  = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (mem_bus.mem_req) busy++;
            else break;
        end
        chk("tmo_busy_cycles", busy, 32'd4);
        chk("tmo_bus_err", bus_err, 32'd1);
        chk("tmo_rdata3", rdata3, 32'd0);
        chk("tmo_stall", stall, 32'd0);
        step();
        rd_en = 1'b0;
        #1;
        chk("tmo_bus_err_end", bus_err, 32'd0);
        chk("tmo_req_idle", mem_bus.mem_req, 32'd0);
`else
        busy = 0;
`endif

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit forming the memory stage of the pipelined RV32I core. Takes the registered ALU address, store data and memory controls from the execute stage, runs a req/ack handshake to a multi-cycle data memory, stalls the pipeline while a transfer is in flight, and returns an aligned, sign- or zero-extended load value to the write-back mux. Byte-enable generation, load extraction and alignment checking are all done here.

## Interface
- `TIMEOUT_CYCLES`, 64: BUSY cycles without ack before abort (only with `LSU_TIMEOUT_EN`).
- `clk` in 1: core clock.
- `rst` in 1: reset, synchronous, active-high.
- `rd_en` in 1: load request from the execute buffer.
- `wr_en` in 1: store request; wins if `rd_en` is also high.
- `func3` in 3: access size and sign, RV32I encoding.
- `addr` in 32: byte address (ALU result).
- `wdata2` in 32: store data, low bits used.
- `rdata3` out 32: extended load result; valid in the DONE cycle.
- `stall` out 1: hold all upstream pipeline registers.
- `misalign` out 1: one-cycle pulse on a misaligned access or illegal `func3`.
- `bus_err` out 1: one-cycle pulse on timeout abort; tied to 0 without the macro.
- `mem_req` out 1: bus request, held until ack.
- `mem_we` out 1: 1 means write.
- `mem_addr` out 32: word-aligned address (`addr & ~3`).
- `mem_wdata` out 32: lane-replicated store data.
- `mem_be` out 4: byte enables.
- `mem_ack` in 1: one-cycle transfer completion.
- `mem_rdata` in 32: read word; valid when `mem_ack` is high.

## Operation
The FSM has three states: IDLE, BUSY and DONE.

**IDLE**
- On `rd_en|wr_en` with a legal, aligned access: register the bus fields and go to BUSY. `stall`=1 combinationally in this cycle.
- On an illegal access: pulse `misalign`, stay in IDLE, `stall`=0, no bus activity. A load gets `rdata3`=0; a store is dropped.

**BUSY**
- `mem_req`=1 and `stall`=1.
- `mem_addr`, `mem_we`, `mem_wdata` and `mem_be` are stable until ack.
- On `mem_ack`: capture the extended `mem_rdata` into `rdata3` (loads only) and go to DONE.

**DONE**
- `stall`=0 and `mem_req`=0.
- Inputs are ignored, because they still hold the old request; the pipeline advances at the end of this cycle.
- Always returns to IDLE.

**Alignment and legality**
- Halfword requires `addr[0]`=0; word requires `addr[1:0]`=0.
- `func3` values 011, 110 and 111 are illegal.
- Stores accept only 000, 001 and 010.

**Stores**
- Byte: `mem_wdata`={4{`wdata2[7:0]`}}, `mem_be`=0001<<`addr[1:0]`.
- Halfword: `mem_wdata`={2{`wdata2[15:0]`}}, `mem_be`=0011<<`addr[1:0]`.
- Word: `mem_wdata`=`wdata2`, `mem_be`=1111.

**Loads**
- The lane is selected by `addr[1:0]`.
- LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- `mem_be` reflects the access size.

**Other rules**
- `mem_ack` outside BUSY is ignored.
- `rdata3` holds its value until the next load completes.
- Stores leave `rdata3` unchanged.

## Timing
- Reset values: state IDLE; all outputs 0, including `rdata3` and `mem_*`.
- Latency from the request cycle C0:
  - `mem_req` rises at C1.
  - An ack at C1+k moves the FSM to DONE at C2+k.
  - `stall` is high for C0 through C1+k, i.e. k+2 cycles; the minimum is 2 stall cycles.
- `stall` is the OR of (IDLE & legal request) and BUSY; it is never registered.
- `misalign` and `bus_err` are single-cycle pulses and never overlap `stall`.
- Reset mid-transfer: on `rst` in BUSY or DONE, state is IDLE at the next edge and `mem_req`/`stall` drop. Any later `mem_ack` is ignored.
- Back-to-back: a new request is accepted only in the cycle after DONE, i.e. no earlier than IDLE.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - A BUSY-cycle counter runs; if it reaches `TIMEOUT_CYCLES` without `mem_ack`, the transfer is aborted.
  - On abort: drop `mem_req`, set `rdata3`=0, pulse `bus_err` in the DONE cycle, go to DONE.
  - The counter clears on leaving BUSY.
- `LSU_TIMEOUT_EN` undefined: no counter, BUSY waits indefinitely, `bus_err`=0.

## Structure
- `lsu_pkg` holds:
  - the state enum `lsu_state_t` (IDLE/BUSY/DONE);
  - the `func3` constants `F3_B`/`F3_H`/`F3_W`/`F3_BU`/`F3_HU`;
  - the byte-enable width constant.
- One sub-module, `lsu_align`: purely combinational. It provides the legality check, store lane replication and `mem_be`, and load extraction and extension. The FSM and registers live in `lsu`.

## Test plan
- LW `addr`=0x100; ack on the 3rd BUSY cycle with `mem_rdata`=0x800000FF -> `mem_addr`=0x100, `mem_be`=1111, `stall` high for 4 cycles, `rdata3`=0x800000FF in DONE.
- LB `addr`=0x103 with `mem_rdata`=0x80ABCD12 and an immediate ack -> `rdata3`=0xFFFFFF80; the same access as LBU -> 0x00000080; LHU `addr`=0x102 -> 0x000080AB.
- SH `addr`=0x202, `wdata2`=0x1234ABCD -> `mem_we`=1, `mem_addr`=0x200, `mem_be`=1100, `mem_wdata`=0xABCDABCD; `rdata3` unchanged.
- LW `addr`=0x101 -> `misalign` pulses 1 cycle, `mem_req` never rises, `stall`=0, `rdata3`=0; `func3`=011 behaves the same.
- `rst` pulsed in the 2nd BUSY cycle -> IDLE, `mem_req`=0 and `stall`=0 next cycle; a `mem_ack` arriving afterwards leaves `rdata3`=0.
- With `LSU_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, no ack -> `mem_req` drops after 4 BUSY cycles, `bus_err` pulses once, `rdata3`=0, then IDLE.
